// File: rtl/led_share_arbiter.sv
// rtl/led_share_arbiter.sv - two-requester round-robin owner of the 16-LED bank
// Also owns the step-tick prescaler and hands grant-qualified step enables to the engines.
module led_share_arbiter #(
  parameter int TICK_DIV   = 25,
  parameter int HOLD_TICKS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] led0,
  input  logic [15:0] led1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        en0,
  output logic        en1,
  output logic        tick,
  output logic [15:0] led
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [TICK_DIV-1:0] presc;
  logic [HW-1:0]       hold_cnt;
  logic [HW-1:0]       hold_nxt;
  logic                last;
  logic                last_nxt;

  assign tick = rst & (presc == '1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc    <= '0;
      state    <= IDLE;
      hold_cnt <= '0;
      last     <= 1'b1;
      led      <= 16'h0000;
    end else begin
      presc    <= presc + TICK_DIV'(1);
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      last     <= last_nxt;
      // Select follows the registered state, so led lags a grant change by one clock.
      case (state)
        G0:      led <= led0;
        G1:      led <= led1;
        default: led <= 16'h0000;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = last ? G0 : G1;
        else if (req0)     state_nxt = G0;
        else if (req1)     state_nxt = G1;
      end
      G0: begin
        // Release is checked before the hold limit so it wins when both happen together.
        if (!req0)             state_nxt = req1 ? G1 : IDLE;
        else if (!req1)        hold_nxt = '0;
        else if (tick) begin
          if (hold_cnt == HOLD_LAST) state_nxt = G1;
          else                       hold_nxt = hold_cnt + HW'(1);
        end
      end
      G1: begin
        if (!req1)             state_nxt = req0 ? G0 : IDLE;
        else if (!req0)        hold_nxt = '0;
        else if (tick) begin
          if (hold_cnt == HOLD_LAST) state_nxt = G0;
          else                       hold_nxt = hold_cnt + HW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) hold_nxt = '0;
  end

  always_comb begin
    last_nxt = last;
    if (state_nxt == G0 && state != G0) last_nxt = 1'b0;
    if (state_nxt == G1 && state != G1) last_nxt = 1'b1;
  end

  always_comb begin
    gnt0 = (state == G0);
    gnt1 = (state == G1);
    en0  = tick & gnt0;
    en1  = tick & gnt1;
  end

endmodule

// File: tb/tb_led_share_arbiter.sv
// tb/tb_led_share_arbiter.sv - directed and random checks of led_share_arbiter against a reference model
module tb_led_share_arbiter;
  localparam int TD = 2;
  localparam int HT = 3;
  localparam int PERIOD = 1 << TD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [15:0] led0 = 16'h0000;
  logic [15:0] led1 = 16'h0000;
  logic        gnt0, gnt1, en0, en1, tick;
  logic [15:0] led;

  led_share_arbiter #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .led0(led0), .led1(led1),
    .gnt0(gnt0), .gnt1(gnt1), .en0(en0), .en1(en1), .tick(tick), .led(led)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Reference model: owner -1 = nobody, else index of the requester holding the bank.
  int          m_cyc;
  int          m_owner;
  int          m_last;
  int          m_waited;
  logic [15:0] m_led;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_tick();
    return rst && (m_cyc % PERIOD == PERIOD - 1);
  endfunction

  task automatic model_edge();
    bit tk;
    bit mine, other;
    int nxt;
    if (!rst) begin
      m_cyc = 0; m_owner = -1; m_last = 1; m_waited = 0; m_led = 16'h0000;
      return;
    end
    tk = (m_cyc % PERIOD == PERIOD - 1);
    m_led = (m_owner == 0) ? led0 : (m_owner == 1) ? led1 : 16'h0000;
    nxt = m_owner;
    if (m_owner < 0) begin
      if (req0 && req1) nxt = 1 - m_last;
      else if (req0)    nxt = 0;
      else if (req1)    nxt = 1;
    end else begin
      mine  = (m_owner == 0) ? req0 : req1;
      other = (m_owner == 0) ? req1 : req0;
      if (!mine)       nxt = other ? 1 - m_owner : -1;
      else if (!other) m_waited = 0;
      else if (tk) begin
        if (m_waited + 1 >= HT) nxt = 1 - m_owner;
        else                    m_waited++;
      end
    end
    if (nxt != m_owner) begin
      m_waited = 0;
      if (nxt >= 0) m_last = nxt;
    end
    m_owner = nxt;
    m_cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("gnt0", gnt0, m_owner == 0);
    check("gnt1", gnt1, m_owner == 1);
    check("tick", tick, m_tick());
    check("en0", en0, m_tick() && m_owner == 0);
    check("en1", en1, m_tick() && m_owner == 1);
    check("led", led, m_led);
    check("gnt_exclusive", gnt0 & gnt1, 0);
  endtask

  int first_tick;
  int pulses;
  int guard;

  initial begin
    m_cyc = 0; m_owner = -1; m_last = 1; m_waited = 0; m_led = 16'h0000;

    // Reset held with both requesting and a busy pattern.
    rst = 0; req0 = 1; req1 = 1; led0 = 16'hFFFF;
    repeat (3) begin
      step();
      check("rst_gnt", {gnt1, gnt0}, 0);
      check("rst_led", led, 0);
      check("rst_tick_en", {tick, en0, en1}, 0);
    end

    // First tick lands in the 4th cycle after release.
    rst = 1; req0 = 0; req1 = 0;
    first_tick = 0;
    for (int k = 1; k <= PERIOD; k++) begin
      step();
      if (tick && first_tick == 0) first_tick = k + 1;
    end
    check("first_tick_cycle", first_tick, PERIOD);

    // Single requester.
    req0 = 1; led0 = 16'hAAAA;
    step();
    check("single_gnt0", gnt0, 1);
    step();
    check("single_led", led, 16'hAAAA);
    pulses = 0;
    repeat (3 * PERIOD) begin
      step();
      if (en0) pulses++;
      check("single_en1_low", en1, 0);
    end
    check("single_en0_count", pulses, 3);

    // Tie from IDLE after reset, then round-robin preemption.
    rst = 0; req0 = 0; req1 = 0;
    step();
    rst = 1; req0 = 1; req1 = 1; led0 = 16'h1234; led1 = 16'h5678;
    step();
    check("tie_first_g0", {gnt1, gnt0}, 2'b01);
    pulses = en0 ? 1 : 0;
    guard = 0;
    while (!gnt1 && guard < 40) begin
      step();
      if (en0) pulses++;
      guard++;
    end
    check("tie_switch_g1", gnt1, 1);
    check("tie_en0_turn", pulses, HT);
    pulses = en1 ? 1 : 0;
    guard = 0;
    while (!gnt0 && guard < 40) begin
      step();
      if (en1) pulses++;
      guard++;
    end
    check("tie_back_g0", gnt0, 1);
    check("tie_en1_turn", pulses, HT);

    // Handoff on release after one tick counted in G0.
    guard = 0;
    while (!en0 && guard < 10) begin step(); guard++; end
    step();
    req0 = 0; led1 = 16'hC3A5;
    step();
    check("handoff_gnt", {gnt1, gnt0}, 2'b10);
    step();
    check("handoff_led", led, 16'hC3A5);

    // Release to idle from G1, then re-request.
    req1 = 0;
    step();
    check("idle_gnt", {gnt1, gnt0}, 0);
    step();
    check("idle_led", led, 0);
    req1 = 1;
    step();
    check("regrant_g1", {gnt1, gnt0}, 2'b10);

    // Reset in G1 with two ticks of contention counted.
    req0 = 1;
    pulses = 0;
    guard = 0;
    while (pulses < 2 && guard < 20) begin
      step();
      if (en1) pulses++;
      guard++;
    end
    step();
    rst = 0;
    step();
    check("midrst_gnt", {gnt1, gnt0}, 0);
    check("midrst_led", led, 0);
    rst = 1;
    step();
    check("midrst_g0_first", {gnt1, gnt0}, 2'b01);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) req0 = ~req0;
      if ($urandom_range(3) == 0) req1 = ~req1;
      led0 = 16'($urandom);
      led1 = 16'($urandom);
      rst  = ($urandom_range(63) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/led_share_arbiter.md
Name: led_share_arbiter

Overview:
- Arbitrates the 16-LED bank between two pattern-generator requesters, so a pattern engine and a second display source can share one LED output.
- Owns the slow step tick: a free-running prescaler produces a one-clock tick every 2^TICK_DIV clocks.
- Issues per-requester step enables, qualified by grant, that drive the engines' en inputs.
- Round-robin grants with a bounded hold time, so neither requester starves the other.

Parameters:
- TICK_DIV, 25: prescaler width. Tick period is 2^TICK_DIV clocks.
- HOLD_TICKS, 8: number of ticks a grantee may keep the bank while the other requester waits. Must be at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- req0  in  1  requester 0 wants the bank. Held high while wanted; deasserting releases the bank.
- req1  in  1  requester 1, same rules as req0.
- led0  in  16  requester 0 pattern.
- led1  in  16  requester 1 pattern.
- gnt0  out  1  requester 0 owns the bank. Registered.
- gnt1  out  1  requester 1 owns the bank. Registered.
- en0  out  1  step enable for requester 0: tick AND gnt0.
- en1  out  1  step enable for requester 1: tick AND gnt1.
- tick  out  1  one-clock pulse every 2^TICK_DIV clocks.
- led  out  16  LED bank output. Registered.

Behaviour:
- All state updates on posedge clk only. rst=0 at an edge forces reset, overriding all other inputs, including mid-grant.
- Reset values:
  - state=IDLE; gnt0=gnt1=0; led=16'h0000.
  - prescaler=0; hold counter=0.
  - last=1, so requester 0 wins the first tie.
  - tick, en0 and en1 are 0 while in reset.
- Prescaler:
  - TICK_DIV-bit counter, increments every clock, wraps from all-ones to 0.
  - tick=1 combinationally when counter is all-ones.
  - First tick is on the 2^TICK_DIV-th clock after reset release; then every 2^TICK_DIV clocks.
- States: IDLE, G0, G1. Moore outputs: gnt0=(state==G0), gnt1=(state==G1). gnt0 and gnt1 are never both 1.
- IDLE:
  - req0 only: go to G0.
  - req1 only: go to G1.
  - Both: grant the one not equal to last.
  - Neither: stay in IDLE.
  - Decision is made every clock, not gated by tick. Grant asserts one clock after req is sampled.
- Gx, where y is the other requester:
  - reqx=0 and reqy=1: go directly to Gy next clock, with no IDLE cycle.
  - reqx=0 and reqy=0: go to IDLE.
  - reqx=1 and reqy=0: stay; hold counter cleared to 0.
  - reqx=1 and reqy=1: hold counter increments on each tick. On a tick with counter==HOLD_TICKS-1, go to Gy and clear the counter. Otherwise stay.
  - Release takes priority over preemption when both occur in the same clock.
- last is updated to x on every entry into Gx.
- Hold counter is cleared on every state change. Width is clog2(HOLD_TICKS+1), and it never exceeds HOLD_TICKS-1.
- led output:
  - Each clock, led <= led0 in G0, led1 in G1, 16'h0000 in IDLE. Mux select is the current registered state.
  - After a grant change, led shows the new source's data from the second clock onward, i.e. one clock after gnt changes.
- Enables:
  - en0/en1 pulse only on tick clocks while the corresponding gnt is high.
  - A non-granted requester never receives an enable, so its pattern freezes.
  - On the clock a switch is decided, en follows the old grant, since gnt is registered.

Test Plan (TICK_DIV=2, HOLD_TICKS=3, so a tick every 4 clocks):
- Reset: hold rst=0 for 3 clocks with req0=req1=1 and led0=16'hFFFF. Required: gnt0=gnt1=0, led=0, tick=en0=en1=0 throughout. After release, first tick 4 clocks later.
- Single requester: after reset, req0=1, led0=16'hAAAA. Required: gnt0=1 one clock later; led=16'hAAAA on the next clock. en0 pulses every 4 clocks coincident with tick; en1 stays 0.
- Tie and preemption: from IDLE after reset, raise req0 and req1 together and keep both high. Required:
  - G0 granted first.
  - gnt switches to 1 on the clock after the 3rd tick with req1 pending.
  - gnt returns to 0 after 3 more ticks.
  - en0 total 3 pulses per turn; gnt never 2'b11.
- Handoff on release: in G0 with req1=1 and 1 tick counted, drop req0. Required: next clock gnt0=0 and gnt1=1 with no IDLE cycle; led shows led1 one clock later. Hold counter restarts from 0.
- Release to idle: in G1 with req0=0, drop req1. Required: next clock gnt=00, led=16'h0000 one clock later. Re-raising req1 grants G1 again, since only req1 is pending.
- Reset mid-grant: in G1 with counter at 2, assert rst=0 for 1 clock with both req high. Required: gnt=00 and led=0 at that edge. After release, G0 is granted first (last reset to 1).
